// File: rtl/ttc_intr_arbiter.sv
// Funnels the timer channels' level interrupts onto one CPU irq with a channel ID,
// servicing one channel at a time: grant, acknowledge, clear pulse, wait for the line to drop.
module ttc_intr_arbiter #(
    parameter int NUM_CH       = 3,
    parameter int DROP_TIMEOUT = 8
) (
    input  logic              pclk,
    input  logic              p_reset,
    input  logic [NUM_CH-1:0] chan_intr,
    input  logic [NUM_CH-1:0] chan_mask,
    input  logic              rr_mode,
    input  logic              irq_ack,
    input  logic              err_clr,
    output logic              irq,
    output logic [1:0]        irq_id,
    output logic [NUM_CH-1:0] clear_intr,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ASSERT, CLEAR, DRAIN} state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic [3:0] drain_cnt;
    logic [3:0] intr4;
    logic [3:0] elig4;
    logic [3:0] clr_onehot;
    logic [1:0] winner;
    logic [1:0] next_ptr;

    // Scan NUM_CH slots starting at ptr (or at 0 for fixed priority); first hit wins.
    function automatic logic [1:0] pick_winner(input logic [3:0] elig,
                                               input logic [1:0] ptr,
                                               input logic       rr);
        logic [1:0] pick;
        logic       found;
        logic [2:0] idx;
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = rr ? ({1'b0, ptr} + 3'(i)) : 3'(i);
            if (idx >= 3'(NUM_CH)) idx = idx - 3'(NUM_CH);
            if (!found && elig[idx[1:0]]) begin
                pick  = idx[1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Vectors are widened to 4 bits so a 2-bit channel index is always in range.
    assign intr4      = 4'(chan_intr);
    assign elig4      = 4'(chan_intr & ~chan_mask);
    assign clr_onehot = 4'b0001 << irq_id;
    assign next_ptr   = (irq_id == 2'(NUM_CH - 1)) ? 2'd0 : irq_id + 2'd1;
    assign winner     = pick_winner(elig4, rr_ptr, rr_mode);

    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            state       <= IDLE;
            irq         <= 1'b0;
            irq_id      <= 2'd0;
            clear_intr  <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= 2'd0;
            drain_cnt   <= 4'd0;
        end else begin
            clear_intr <= '0;
            if (err_clr) timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig4 != 4'd0) begin
                        irq_id <= winner;
                        irq    <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ASSERT;
                    end
                end
                ASSERT: begin
                    // An ack beats a simultaneous withdrawal of the granted line.
                    if (irq_ack) begin
                        irq        <= 1'b0;
                        clear_intr <= clr_onehot[NUM_CH-1:0];
                        state      <= CLEAR;
                    end else if (!elig4[irq_id]) begin
                        irq   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    rr_ptr    <= next_ptr;
                    drain_cnt <= 4'd0;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (!intr4[irq_id]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (drain_cnt == 4'(DROP_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ttc_intr_arbiter.sv
// Directed bench for ttc_intr_arbiter: expected grant IDs are queued as stimulus is
// applied and popped when irq rises; other outputs are checked against constants.
module tb_ttc_intr_arbiter;

    logic       pclk;
    logic       p_reset;
    logic [2:0] chan_intr;
    logic [2:0] chan_mask;
    logic       rr_mode;
    logic       irq_ack;
    logic       err_clr;
    logic       irq;
    logic [1:0] irq_id;
    logic [2:0] clear_intr;
    logic       busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];

    ttc_intr_arbiter #(.NUM_CH(3), .DROP_TIMEOUT(8)) dut (
        .pclk(pclk), .p_reset(p_reset), .chan_intr(chan_intr), .chan_mask(chan_mask),
        .rr_mode(rr_mode), .irq_ack(irq_ack), .err_clr(err_clr), .irq(irq),
        .irq_id(irq_id), .clear_intr(clear_intr), .busy(busy), .timeout_err(timeout_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag, output logic [1:0] e);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_irq"}, 32'(irq), 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue observed=empty expected=pending_grant", tag);
            e = 2'd0;
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_id"}, 32'(irq_id), 32'(e));
        end
    endtask

    // Grant, ack, clear pulse; optionally drop the line, finish DRAIN, then apply 'after'.
    task automatic service(input string tag, input bit drop, input logic [2:0] after);
        logic [1:0] e;
        wait_grant(tag, e);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk({tag, "_clr"}, 32'(clear_intr), 32'(3'b001 << e));
        chk({tag, "_irq_low"}, 32'(irq), 32'd0);
        if (drop) chan_intr[e] = 1'b0;
        step();
        chk({tag, "_clr_end"}, 32'(clear_intr), 32'd0);
        chk({tag, "_busy_drain"}, 32'(busy), 32'd1);
        if (drop) begin
            step();
            chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
            chan_intr = after;
        end
    endtask

    initial begin
        logic [1:0] e;
        p_reset   = 1'b1;
        chan_intr = 3'b000;
        chan_mask = 3'b000;
        rr_mode   = 1'b0;
        irq_ack   = 1'b0;
        err_clr   = 1'b0;
        step();
        step();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_clr", 32'(clear_intr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        p_reset = 1'b0;

        // Single channel, one-cycle grant latency
        chan_intr = 3'b001;
        exp_q.push_back(2'd0);
        step();
        chk("t1_latency", 32'(irq), 32'd1);
        service("t1", 1'b1, 3'b000);

        // Round-robin with all lines pending
        p_reset = 1'b1;
        step();
        p_reset   = 1'b0;
        rr_mode   = 1'b1;
        chan_intr = 3'b111;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        service("rr0", 1'b1, 3'b111);
        service("rr1", 1'b1, 3'b111);
        service("rr2", 1'b1, 3'b111);
        service("rr3", 1'b1, 3'b110);

        // Withdrawal by masking before ack: no clear, pointer stays at 1
        exp_q.push_back(2'd1);
        wait_grant("mask", e);
        chan_mask = 3'b010;
        step();
        chk("mask_irq", 32'(irq), 32'd0);
        chk("mask_clr", 32'(clear_intr), 32'd0);
        chk("mask_busy", 32'(busy), 32'd0);
        chan_mask = 3'b000;
        chan_intr = 3'b111;
        exp_q.push_back(2'd1);
        service("mask_regrant", 1'b1, 3'b100);

        // Stuck line: timeout after 8 DRAIN cycles, then re-grant
        exp_q.push_back(2'd2);
        service("to", 1'b0, 3'b100);
        repeat (7) step();
        chk("to_terr_early", 32'(timeout_err), 32'd0);
        chk("to_busy_early", 32'(busy), 32'd1);
        step();
        chk("to_terr_set", 32'(timeout_err), 32'd1);
        chk("to_busy_idle", 32'(busy), 32'd0);
        exp_q.push_back(2'd2);
        wait_grant("to_regrant", e);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr_terr", 32'(timeout_err), 32'd0);
        chk("errclr_irq_held", 32'(irq), 32'd1);

        // Ack and withdrawal in the same cycle: the ack wins
        irq_ack   = 1'b1;
        chan_intr = 3'b000;
        step();
        irq_ack = 1'b0;
        chk("ackwd_clr", 32'(clear_intr), 32'd4);
        chk("ackwd_irq", 32'(irq), 32'd0);
        step();
        chk("ackwd_clr_end", 32'(clear_intr), 32'd0);
        step();
        chk("ackwd_busy", 32'(busy), 32'd0);

        // Reset asserted during CLEAR
        chan_intr = 3'b010;
        exp_q.push_back(2'd1);
        wait_grant("rstclr", e);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("rstclr_pulse", 32'(clear_intr), 32'd2);
        p_reset = 1'b1;
        #1;
        chk("rstclr_clr", 32'(clear_intr), 32'd0);
        chk("rstclr_irq", 32'(irq), 32'd0);
        chk("rstclr_busy", 32'(busy), 32'd0);
        step();
        chk("rstclr_id", 32'(irq_id), 32'd0);
        p_reset = 1'b0;
        exp_q.push_back(2'd1);
        step();
        chk("rstclr_resume", 32'(irq), 32'd1);
        wait_grant("rstclr_regrant", e);
        irq_ack = 1'b1;
        step();
        irq_ack   = 1'b0;
        chan_intr = 3'b000;
        step();
        step();
        chk("rstclr_done_busy", 32'(busy), 32'd0);

        // Fixed priority: channel 0 always wins
        rr_mode   = 1'b0;
        chan_intr = 3'b111;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        service("fp0", 1'b1, 3'b111);
        service("fp1", 1'b1, 3'b111);
        service("fp2", 1'b1, 3'b000);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
